// File: rtl/debounce_pkg.sv
// Shared types and default constants for the push-button debouncer.
package debounce_pkg;

   // Debouncer FSM states. The accepted level is 1 in PRESSED and WAIT_RELEASE.
   typedef enum logic [1:0] {
      ST_IDLE         = 2'd0,
      ST_WAIT_PRESS   = 2'd1,
      ST_PRESSED      = 2'd2,
      ST_WAIT_RELEASE = 2'd3
   } state_t;

   // 10 ms of stability at 100 MHz, and a counter wide enough to hold it.
   localparam int unsigned STABLE_CYCLES_DEF = 1_000_000;
   localparam int unsigned CNT_W_DEF         = 20;

   // Debounced level implied by a state.
   function automatic logic state_level(input state_t s);
      return (s == ST_PRESSED) || (s == ST_WAIT_RELEASE);
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer bringing the raw button level into the clk domain.
module sync_2ff (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic meta_q;
   logic sync_q;

   // Double registering; the first flop may go metastable, the second settles it.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= d;
         sync_q <= meta_q;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/debounce_pulse.sv
// Push-button debouncer: synchronizes btn_in, requires STABLE_CYCLES of a
// steady level before accepting it, and emits one-cycle press/release pulses
// plus a wrapping count of accepted presses.
module debounce_pulse
   import debounce_pkg::*;
#(
   parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_DEF,
   parameter int unsigned CNT_W         = CNT_W_DEF
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btn_in,
   output logic       level_out,
   output logic       pulse_out,
   output logic       release_out,
   output logic [7:0] press_count
);

   // Terminal stability count: the level has held for STABLE_CYCLES edges.
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

   logic             btn_s;
   state_t           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             level_q;
   logic             pulse_q;
   logic             release_q;
   logic [7:0]       count_q;
   logic [7:0]       count_d;

   sync_2ff u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (btn_in),
      .q     (btn_s)
   );

   // Incremented values; the press counter wraps naturally at 8 bits.
   assign cnt_d   = cnt_q + CNT_W'(1);
   assign count_d = count_q + 8'd1;

   // Debounce FSM with stability counter and registered outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         level_q   <= 1'b0;
         pulse_q   <= 1'b0;
         release_q <= 1'b0;
         count_q   <= '0;
      end else begin
         pulse_q   <= 1'b0;
         release_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               cnt_q <= '0;
               if (btn_s) begin
                  state_q <= ST_WAIT_PRESS;
               end
            end
            ST_WAIT_PRESS: begin
               if (!btn_s) begin
                  // Bounce: level dropped before qualifying.
                  state_q <= ST_IDLE;
                  cnt_q   <= '0;
               end else if (cnt_q == CNT_MAX) begin
                  state_q <= ST_PRESSED;
                  cnt_q   <= '0;
                  level_q <= state_level(ST_PRESSED);
                  pulse_q <= 1'b1;
                  count_q <= count_d;
               end else begin
                  cnt_q <= cnt_d;
               end
            end
            ST_PRESSED: begin
               cnt_q <= '0;
               if (!btn_s) begin
                  state_q <= ST_WAIT_RELEASE;
               end
            end
            ST_WAIT_RELEASE: begin
               if (btn_s) begin
                  // Glitch low while held: stay pressed, no release.
                  state_q <= ST_PRESSED;
                  cnt_q   <= '0;
               end else if (cnt_q == CNT_MAX) begin
                  state_q   <= ST_IDLE;
                  cnt_q     <= '0;
                  level_q   <= state_level(ST_IDLE);
                  release_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_d;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               cnt_q   <= '0;
               level_q <= 1'b0;
            end
         endcase
      end
   end

   assign level_out   = level_q;
   assign pulse_out   = pulse_q;
   assign release_out = release_q;
   assign press_count = count_q;

endmodule

// File: doc/debounce_pulse.md
DEBOUNCE_PULSE -- requirements
Module: debounce_pulse

Interface
REQ-001 The block SHALL have parameter STABLE_CYCLES, default 1_000_000, meaning the number of clk cycles an input level must hold to be accepted (10 ms at 100 MHz); legal range 2..2^CNT_W.
REQ-002 The block SHALL have parameter CNT_W, default 20, meaning the stability counter width.
REQ-003 The block SHALL have port clk, input, 1, the single system clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1; it is asynchronous and active-low.
REQ-005 The block SHALL have port btn_in, input, 1, the raw asynchronous push-button level.
REQ-006 The block SHALL have port level_out, output, 1, the debounced button level.
REQ-007 The block SHALL have port pulse_out, output, 1, a one-clk pulse on each accepted press; it is the T source for the downstream toggle flip-flop.
REQ-008 The block SHALL have port release_out, output, 1, a one-clk pulse on each accepted release.
REQ-009 The block SHALL have port press_count, output, 8, the count of accepted presses.

Function
REQ-010 btn_in SHALL pass through a two-flop synchronizer; the FSM sees only its output btn_s, 2 edges after btn_in changes.
REQ-011 The FSM SHALL have states IDLE (level 0), WAIT_PRESS, PRESSED (level 1) and WAIT_RELEASE.
REQ-012 IDLE with btn_s=1 SHALL go to WAIT_PRESS and set cnt=0; otherwise it stays in IDLE.
REQ-013 WAIT_PRESS with btn_s=0 SHALL return to IDLE with no pulse, cnt cleared (bounce rejected).
REQ-014 WAIT_PRESS with btn_s=1 and cnt==STABLE_CYCLES-1 SHALL go to PRESSED, assert pulse_out for one cycle and increment press_count; otherwise it SHALL increment cnt.
REQ-015 PRESSED with btn_s=0 SHALL go to WAIT_RELEASE and set cnt=0.
REQ-016 WAIT_RELEASE with btn_s=1 SHALL return to PRESSED with no release_out.
REQ-017 WAIT_RELEASE with btn_s=0 and cnt==STABLE_CYCLES-1 SHALL go to IDLE and assert release_out for one cycle; otherwise it SHALL increment cnt.
REQ-018 Latency SHALL be fixed: btn_in first sampled high at edge k and held → pulse_out high in the cycle after edge k+2+STABLE_CYCLES; release is symmetric.
REQ-019 level_out SHALL be 1 in PRESSED and WAIT_RELEASE and 0 otherwise, and SHALL be registered.
REQ-020 pulse_out and release_out SHALL be registered, never high in the same cycle, and never high for more than 1 consecutive cycle.
REQ-021 press_count SHALL wrap from 255 to 0 without saturation.
REQ-022 cnt SHALL never exceed STABLE_CYCLES-1, and only WAIT_PRESS and WAIT_RELEASE SHALL advance it.
REQ-023 A btn_s toggle in the same cycle cnt reaches STABLE_CYCLES-1 SHALL be treated as instability: no pulse, rules REQ-013/REQ-016 apply.

Reset
REQ-024 When reset=0, asynchronously: synchronizer flops=0, state=IDLE, cnt=0, level_out=0, pulse_out=0, release_out=0, press_count=0.
REQ-025 Reset asserted mid-WAIT_PRESS or mid-PRESSED SHALL abort with no pulse or release emitted on deassertion.
REQ-026 After reset deassertion with btn_in already held high, a full press qualification SHALL occur, yielding exactly one pulse_out.

Structure
REQ-027 A shared package debounce_pkg SHALL hold the FSM state type (2-bit encoding) and the default STABLE_CYCLES and CNT_W constants.
REQ-028 The synchronizer SHALL be a separate sub-module sync_2ff with ports clk, reset, d and q.
REQ-029 The remaining logic SHALL be one FSM plus counter, with no derived or divided clocks.

Verification (STABLE_CYCLES=4, CNT_W=3)
REQ-030 Reset: reset=0 with btn_in=1 → all outputs 0; release reset and hold btn_in=1 → exactly one pulse_out, 6 edges after the first sampling edge.
REQ-031 Clean press: btn_in rises, sampled at edge 0, held 20 cycles → pulse_out high only after edge 6, level_out=1 from edge 6, press_count=1.
REQ-032 Bounce: btn_in pattern 1,0,1,0 for 1 cycle each, then 0 → no pulse_out, level_out stays 0, press_count=0.
REQ-033 Release glitch: in PRESSED, btn_in low for 2 cycles then high → no release_out, level_out stays 1.
REQ-034 Wrap: 256 clean press/release pairs → press_count returns to 0, with 256 pulse_out and 256 release_out observed.
REQ-035 Reset mid-operation: reset=0 asserted in WAIT_PRESS at cnt=2 → immediately state=IDLE and outputs 0, with no pulse emitted.
